// File: rtl/icb_pkg.sv
// Shared ICB definitions: default bus widths, arbitration mode encodings and
// the width helper used for master IDs.
package icb_pkg;

   localparam int ICB_AW = 32;
   localparam int ICB_DW = 32;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // A single master still needs a one-bit ID so vectors never collapse to zero width.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/icb_arb_fifo.sv
// Synchronous FIFO of master IDs, one entry per outstanding command; the
// head entry names the master owed the next response.
module icb_arb_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);
   assign head  = mem_q[rd_ptr_q];

   // NOTE: every signal gets its default before any branch, so no path leaves
   // a value unassigned and no latch is inferred; combinational code uses '='.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // NOTE: state flops use '<=' so all registers update together on the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // NOTE: storage is not reset; an entry is only read after it was written,
   // and leaving it out of reset lets it map onto plain register-file cells.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/icb_arb.sv
// N-to-1 ICB arbiter: combinational command mux with grant lock, and an ID
// FIFO that routes in-order responses back to the issuing master.
module icb_arb
   import icb_pkg::*;
#(
   parameter int N_MST    = 2,
   parameter int AW       = ICB_AW,
   parameter int DW       = ICB_DW,
   parameter int OUTS     = 2,
   parameter int ARB_MODE = ARB_RR
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_MST-1:0]        m_icb_cmd_valid,
   output logic [N_MST-1:0]        m_icb_cmd_ready,
   input  logic [N_MST*AW-1:0]     m_icb_cmd_addr,
   input  logic [N_MST-1:0]        m_icb_cmd_read,
   input  logic [N_MST*DW-1:0]     m_icb_cmd_wdata,
   input  logic [N_MST*DW/8-1:0]   m_icb_cmd_wmask,
   output logic [N_MST-1:0]        m_icb_rsp_valid,
   input  logic [N_MST-1:0]        m_icb_rsp_ready,
   output logic [N_MST-1:0]        m_icb_rsp_err,
   output logic [N_MST*DW-1:0]     m_icb_rsp_rdata,
   output logic                    s_icb_cmd_valid,
   input  logic                    s_icb_cmd_ready,
   output logic [AW-1:0]           s_icb_cmd_addr,
   output logic                    s_icb_cmd_read,
   output logic [DW-1:0]           s_icb_cmd_wdata,
   output logic [DW/8-1:0]         s_icb_cmd_wmask,
   input  logic                    s_icb_rsp_valid,
   output logic                    s_icb_rsp_ready,
   input  logic                    s_icb_rsp_err,
   input  logic [DW-1:0]           s_icb_rsp_rdata,
   output logic                    orphan_o
);

   localparam int IW = id_width(N_MST);
   localparam int MW = DW / 8;

   logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]    lock_idx_q, lock_idx_d;
   logic             lock_q, lock_d;
   logic             orphan_q, orphan_d;
   logic             fifo_full, fifo_empty, push, pop;
   logic [IW-1:0]    head, grant, cand;
   logic [N_MST-1:0] elig;
   logic             found;
   int               j;

   icb_arb_fifo #(
      .WIDTH (IW),
      .DEPTH (OUTS)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (grant),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (head)
   );

   // Full masks every request, even when a pop lands this cycle.
   always_comb begin
      elig  = m_icb_cmd_valid & {N_MST{~fifo_full}};
      grant = '0;
      cand  = '0;
      found = 1'b0;
      j     = 0;
      if (lock_q) begin
         grant = lock_idx_q;
      end else if (ARB_MODE == ARB_FIXED) begin
         for (int i = N_MST - 1; i >= 0; i--) begin
            cand = IW'(i);
            if (elig[cand]) grant = cand;
         end
      end else begin
         for (int k = 0; k < N_MST; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= N_MST) j = j - N_MST;
            cand = IW'(j);
            if (!found && elig[cand]) begin
               grant = cand;
               found = 1'b1;
            end
         end
      end
   end

   always_comb begin
      s_icb_cmd_valid        = m_icb_cmd_valid[grant] & ~fifo_full;
      s_icb_cmd_addr         = m_icb_cmd_addr[grant*AW +: AW];
      s_icb_cmd_read         = m_icb_cmd_read[grant];
      s_icb_cmd_wdata        = m_icb_cmd_wdata[grant*DW +: DW];
      s_icb_cmd_wmask        = m_icb_cmd_wmask[grant*MW +: MW];
      m_icb_cmd_ready        = '0;
      m_icb_cmd_ready[grant] = s_icb_cmd_valid & s_icb_cmd_ready;
      push                   = s_icb_cmd_valid & s_icb_cmd_ready;

      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      if (s_icb_cmd_valid && !s_icb_cmd_ready) begin
         lock_d     = 1'b1;
         lock_idx_d = grant;
      end else if (push) begin
         lock_d = 1'b0;
      end

      rr_ptr_d = rr_ptr_q;
      if (ARB_MODE == ARB_RR && push) begin
         rr_ptr_d = (grant == IW'(N_MST - 1)) ? '0 : grant + IW'(1);
      end
   end

   // With nothing outstanding the slave response is sunk and flagged.
   always_comb begin
      m_icb_rsp_valid = '0;
      m_icb_rsp_err   = '0;
      m_icb_rsp_rdata = '0;
      s_icb_rsp_ready = 1'b1;
      orphan_d        = orphan_q;
      if (!fifo_empty) begin
         m_icb_rsp_valid[head]            = s_icb_rsp_valid;
         m_icb_rsp_err[head]              = s_icb_rsp_err;
         m_icb_rsp_rdata[head*DW +: DW]   = s_icb_rsp_rdata;
         s_icb_rsp_ready                  = m_icb_rsp_ready[head];
      end else if (s_icb_rsp_valid) begin
         orphan_d = 1'b1;
      end
      pop = s_icb_rsp_valid & s_icb_rsp_ready & ~fifo_empty;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q   <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         orphan_q   <= 1'b0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         orphan_q   <= orphan_d;
      end
   end

   assign orphan_o = orphan_q;

endmodule

// File: tb/tb_icb_arb.sv
// Directed bench: a round-robin and a fixed-priority arbiter share the same
// stimulus; each is compared against hand-computed grants and routing.
module tb_icb_arb;

   localparam int N  = 3;
   localparam int AW = 8;
   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    m_valid;
   logic [N*AW-1:0] m_addr;
   logic [N-1:0]    m_read;
   logic [N*DW-1:0] m_wdata;
   logic [N-1:0]    m_wmask;
   logic [N-1:0]    m_rsp_ready;
   logic            s_cmd_ready;
   logic            s_rsp_valid;
   logic            s_rsp_err;
   logic [DW-1:0]   s_rsp_rdata;

   logic [N-1:0]    rr_m_cmd_ready, fx_m_cmd_ready;
   logic [N-1:0]    rr_m_rsp_valid, fx_m_rsp_valid;
   logic [N-1:0]    rr_m_rsp_err, fx_m_rsp_err;
   logic [N*DW-1:0] rr_m_rsp_rdata, fx_m_rsp_rdata;
   logic            rr_s_cmd_valid, fx_s_cmd_valid;
   logic [AW-1:0]   rr_s_cmd_addr, fx_s_cmd_addr;
   logic            rr_s_cmd_read, fx_s_cmd_read;
   logic [DW-1:0]   rr_s_cmd_wdata, fx_s_cmd_wdata;
   logic            rr_s_cmd_wmask, fx_s_cmd_wmask;
   logic            rr_s_rsp_ready, fx_s_rsp_ready;
   logic            rr_orphan, fx_orphan;

   int n_checks = 0;
   int n_errors = 0;
   int g, h;
   int exp_rr [4] = '{0, 2, 0, 2};

   always #5 clk = ~clk;

   icb_arb #(.N_MST(N), .AW(AW), .DW(DW), .OUTS(2), .ARB_MODE(1)) u_rr (
      .clk (clk), .rst (rst),
      .m_icb_cmd_valid (m_valid), .m_icb_cmd_ready (rr_m_cmd_ready),
      .m_icb_cmd_addr (m_addr), .m_icb_cmd_read (m_read),
      .m_icb_cmd_wdata (m_wdata), .m_icb_cmd_wmask (m_wmask),
      .m_icb_rsp_valid (rr_m_rsp_valid), .m_icb_rsp_ready (m_rsp_ready),
      .m_icb_rsp_err (rr_m_rsp_err), .m_icb_rsp_rdata (rr_m_rsp_rdata),
      .s_icb_cmd_valid (rr_s_cmd_valid), .s_icb_cmd_ready (s_cmd_ready),
      .s_icb_cmd_addr (rr_s_cmd_addr), .s_icb_cmd_read (rr_s_cmd_read),
      .s_icb_cmd_wdata (rr_s_cmd_wdata), .s_icb_cmd_wmask (rr_s_cmd_wmask),
      .s_icb_rsp_valid (s_rsp_valid), .s_icb_rsp_ready (rr_s_rsp_ready),
      .s_icb_rsp_err (s_rsp_err), .s_icb_rsp_rdata (s_rsp_rdata),
      .orphan_o (rr_orphan)
   );

   icb_arb #(.N_MST(N), .AW(AW), .DW(DW), .OUTS(2), .ARB_MODE(0)) u_fx (
      .clk (clk), .rst (rst),
      .m_icb_cmd_valid (m_valid), .m_icb_cmd_ready (fx_m_cmd_ready),
      .m_icb_cmd_addr (m_addr), .m_icb_cmd_read (m_read),
      .m_icb_cmd_wdata (m_wdata), .m_icb_cmd_wmask (m_wmask),
      .m_icb_rsp_valid (fx_m_rsp_valid), .m_icb_rsp_ready (m_rsp_ready),
      .m_icb_rsp_err (fx_m_rsp_err), .m_icb_rsp_rdata (fx_m_rsp_rdata),
      .s_icb_cmd_valid (fx_s_cmd_valid), .s_icb_cmd_ready (s_cmd_ready),
      .s_icb_cmd_addr (fx_s_cmd_addr), .s_icb_cmd_read (fx_s_cmd_read),
      .s_icb_cmd_wdata (fx_s_cmd_wdata), .s_icb_cmd_wmask (fx_s_cmd_wmask),
      .s_icb_rsp_valid (s_rsp_valid), .s_icb_rsp_ready (fx_s_rsp_ready),
      .s_icb_rsp_err (s_rsp_err), .s_icb_rsp_rdata (s_rsp_rdata),
      .orphan_o (fx_orphan)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      next_cyc();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst         = 1'b1;
      m_valid     = '0;
      m_addr      = {8'hA2, 8'hA1, 8'hA0};
      m_read      = 3'b010;
      m_wdata     = {8'h12, 8'h11, 8'h10};
      m_wmask     = 3'b111;
      m_rsp_ready = 3'b111;
      s_cmd_ready = 1'b0;
      s_rsp_valid = 1'b0;
      s_rsp_err   = 1'b0;
      s_rsp_rdata = '0;
      next_cyc();
      next_cyc();
      rst = 1'b0;

      // Reset state
      #4;
      check("rst_orphan_rr", rr_orphan, 0);
      check("rst_orphan_fx", fx_orphan, 0);
      check("rst_cmd_ready", rr_m_cmd_ready, 0);
      check("rst_cmd_valid", rr_s_cmd_valid, 0);
      check("rst_rsp_valid", rr_m_rsp_valid, 0);
      check("rst_rsp_ready", rr_s_rsp_ready, 1);
      next_cyc();

      // Round-robin rotation with responses one cycle behind
      for (int c = 0; c < 6; c++) begin
         m_valid     = 3'b111;
         s_cmd_ready = 1'b1;
         s_rsp_valid = (c > 0);
         s_rsp_rdata = 8'(8'h50 + c);
         s_rsp_err   = (c % 2 == 1);
         #4;
         g = c % 3;
         check($sformatf("rr_grant%0d", c), rr_m_cmd_ready, 32'd1 << g);
         check($sformatf("rr_addr%0d", c), rr_s_cmd_addr, 32'hA0 + g);
         check($sformatf("rr_read%0d", c), rr_s_cmd_read, (g == 1) ? 1 : 0);
         check($sformatf("fx_grant%0d", c), fx_m_cmd_ready, 3'b001);
         if (c > 0) begin
            h = (c - 1) % 3;
            check($sformatf("rr_rspv%0d", c), rr_m_rsp_valid, 32'd1 << h);
            check($sformatf("rr_rdata%0d", c), rr_m_rsp_rdata[h*8 +: 8], 32'h50 + c);
            check($sformatf("rr_err%0d", c), rr_m_rsp_err, (c % 2 == 1) ? (32'd1 << h) : 32'd0);
            check($sformatf("fx_rspv%0d", c), fx_m_rsp_valid, 3'b001);
         end
         next_cyc();
      end
      m_valid     = '0;
      s_rsp_valid = 1'b1;
      s_rsp_rdata = 8'h56;
      #4;
      check("rr_last_rsp", rr_m_rsp_valid, 3'b100);
      check("fx_last_rsp", fx_m_rsp_valid, 3'b001);
      next_cyc();
      s_rsp_valid = 1'b0;
      rst_pulse();

      // Fixed priority starves master 2 until master 0 drops
      for (int c = 0; c < 4; c++) begin
         m_valid     = (c < 3) ? 3'b101 : 3'b100;
         s_cmd_ready = 1'b1;
         s_rsp_valid = (c > 0);
         #4;
         check($sformatf("fx_prio%0d", c), fx_m_cmd_ready, (c < 3) ? 3'b001 : 3'b100);
         check($sformatf("rr_alt%0d", c), rr_m_cmd_ready, 32'd1 << exp_rr[c]);
         if (c == 3) check("fx_addr_m2", fx_s_cmd_addr, 8'hA2);
         next_cyc();
      end
      m_valid     = '0;
      s_rsp_valid = 1'b1;
      next_cyc();
      s_rsp_valid = 1'b0;
      rst_pulse();

      // Lock holds master 1 through four stalled cycles
      for (int c = 0; c < 6; c++) begin
         m_valid     = (c == 0) ? 3'b010 : (c < 5) ? 3'b011 : 3'b001;
         s_cmd_ready = (c >= 4);
         #4;
         check($sformatf("lk_addr_rr%0d", c), rr_s_cmd_addr, (c < 5) ? 8'hA1 : 8'hA0);
         check($sformatf("lk_addr_fx%0d", c), fx_s_cmd_addr, (c < 5) ? 8'hA1 : 8'hA0);
         check($sformatf("lk_rdy_fx%0d", c), fx_m_cmd_ready,
               (c < 4) ? 3'b000 : (c == 4) ? 3'b010 : 3'b001);
         check($sformatf("lk_vld_rr%0d", c), rr_s_cmd_valid, 1);
         next_cyc();
      end
      m_valid = '0;
      rst_pulse();

      // Full FIFO blocks push, including the cycle of the first pop
      m_valid     = 3'b111;
      s_cmd_ready = 1'b1;
      #4;
      check("full_g0", rr_m_cmd_ready, 3'b001);
      next_cyc();
      #4;
      check("full_g1", rr_m_cmd_ready, 3'b010);
      next_cyc();
      #4;
      check("full_rdy_rr", rr_m_cmd_ready, 3'b000);
      check("full_vld_rr", rr_s_cmd_valid, 0);
      check("full_rdy_fx", fx_m_cmd_ready, 3'b000);
      next_cyc();
      s_rsp_valid = 1'b1;
      s_rsp_rdata = 8'h77;
      #4;
      check("pop_rdy_rr", rr_m_cmd_ready, 3'b000);
      check("pop_rdy_fx", fx_m_cmd_ready, 3'b000);
      check("pop_rspv", rr_m_rsp_valid, 3'b001);
      check("pop_rdata", rr_m_rsp_rdata[7:0], 8'h77);
      next_cyc();
      s_rsp_valid = 1'b0;
      m_valid     = 3'b011;
      #4;
      check("resume_rr", rr_m_cmd_ready, 3'b001);
      check("resume_vld", rr_s_cmd_valid, 1);
      check("resume_fx", fx_m_cmd_ready, 3'b001);
      next_cyc();

      // Reset with two outstanding; late response is an orphan
      m_valid = '0;
      rst_pulse();
      s_rsp_valid = 1'b1;
      s_rsp_rdata = 8'h88;
      #4;
      check("late_ready_rr", rr_s_rsp_ready, 1);
      check("late_rspv_rr", rr_m_rsp_valid, 0);
      check("late_rspv_fx", fx_m_rsp_valid, 0);
      check("late_orphan_pre", rr_orphan, 0);
      next_cyc();
      s_rsp_valid = 1'b0;
      #4;
      check("orphan_rr", rr_orphan, 1);
      check("orphan_fx", fx_orphan, 1);
      next_cyc();
      m_valid     = 3'b011;
      s_cmd_ready = 1'b0;
      #4;
      check("rrptr_cleared", rr_s_cmd_addr, 8'hA0);
      check("orphan_sticky", rr_orphan, 1);
      next_cyc();
      m_valid = '0;
      rst_pulse();
      #4;
      check("orphan_clr_rr", rr_orphan, 0);
      check("orphan_clr_fx", fx_orphan, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
